lmsm_sequencer: RTL and testbench

Decode-stage micro-sequencer for load-multiple (LM, opcode 4'b0110) and store-multiple (SM, opcode 4'b0111). It sits between decode and the register file / execute boundary, and expands one LM/SM instruction into one single-register transfer micro-op per set bit of its 8-bit mask. While those micro-ops drain, it holds fetch/decode. It drives register-file read port 1 to capture the base register Ra, and read port 2 to source SM store data.

---
 rtl/lmsm_sequencer.sv | 133 +++++++++++++
 tb/tb_lmsm_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lmsm_sequencer.sv
// Expands one LM/SM instruction into one register-transfer micro-op per set mask bit.
// Latency: the first micro-op is valid the cycle after accept; one micro-op per ex_ready beat after that.
// Backpressure: while ex_ready is low, all uop_* outputs and all state hold; decode is stalled in RUN.
module lmsm_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dec_valid,
    input  logic [15:0] dec_instr,
    input  logic [15:0] dec_pc,
    output logic        dec_ready,
    output logic        fetch_stall,
    output logic [2:0]  rf_rd_addr1,
    input  logic [15:0] rf_data_1,
    output logic [2:0]  rf_rd_addr2,
    input  logic        ex_ready,
    input  logic        flush,
    output logic        uop_valid,
    output logic        uop_load,
    output logic [2:0]  uop_reg,
    output logic [15:0] uop_addr,
    output logic [15:0] uop_pc,
    output logic        uop_last
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;

    state_t      state;
    state_t      state_nxt;

    logic [7:0]  mask_r;
    logic [15:0] base_r;
    logic [2:0]  cnt_r;
    logic        kind_r;
    logic [15:0] pc_r;

    logic [3:0]  opcode;
    logic        is_lmsm;
    logic        accept;
    logic        advance;
    logic [7:0]  mask_rest;
    logic        one_left;
    logic [2:0]  low_idx;
    logic        unused_instr_bit;

    assign opcode           = dec_instr[15:12];
    assign is_lmsm          = (opcode == OP_LM) || (opcode == OP_SM);
    assign accept           = (state == IDLE) && dec_valid && is_lmsm && !flush;
    assign advance          = (state == RUN) && ex_ready && !flush;
    assign unused_instr_bit = dec_instr[8];

    // Clearing the lowest set bit also tells us whether exactly one bit remains.
    assign mask_rest = mask_r & (mask_r - 8'd1);
    assign one_left  = (mask_r != 8'd0) && (mask_rest == 8'd0);

    always_comb begin
        low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_r[i]) begin
                low_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Flush outranks both accept and advance.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && (dec_instr[7:0] != 8'd0)) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (ex_ready && one_left) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Base is captured once, so an LM that overwrites Ra cannot disturb later addresses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_r <= 8'd0;
            base_r <= 16'd0;
            cnt_r  <= 3'd0;
            kind_r <= 1'b0;
            pc_r   <= 16'd0;
        end else if (flush) begin
            mask_r <= 8'd0;
        end else if (accept) begin
            mask_r <= dec_instr[7:0];
            base_r <= rf_data_1;
            cnt_r  <= 3'd0;
            kind_r <= (opcode == OP_LM);
            pc_r   <= dec_pc;
        end else if (advance) begin
            mask_r <= mask_rest;
            cnt_r  <= cnt_r + 3'd1;
        end
    end

    always_comb begin
        dec_ready   = (state == IDLE);
        fetch_stall = (state == RUN);
        rf_rd_addr1 = dec_instr[11:9];
        uop_valid   = (state == RUN);
        uop_load    = kind_r;
        uop_reg     = low_idx;
        uop_addr    = base_r + {13'd0, cnt_r};
        uop_pc      = pc_r;
        uop_last    = (state == RUN) && one_left;
        rf_rd_addr2 = low_idx;
    end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Scoreboarded bench for lmsm_sequencer: directed LM/SM vectors, backpressure, flush and async reset.
module tb_lmsm_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dec_valid = 1'b0;
    logic [15:0] dec_instr = 16'h0000;
    logic [15:0] dec_pc = 16'h0000;
    logic        dec_ready;
    logic        fetch_stall;
    logic [2:0]  rf_rd_addr1;
    logic [15:0] rf_data_1;
    logic [2:0]  rf_rd_addr2;
    logic        ex_ready = 1'b1;
    logic        flush = 1'b0;
    logic        uop_valid;
    logic        uop_load;
    logic [2:0]  uop_reg;
    logic [15:0] uop_addr;
    logic [15:0] uop_pc;
    logic        uop_last;

    logic [15:0] rf [8];

    typedef struct packed {
        logic        load;
        logic [2:0]  rg;
        logic [15:0] addr;
        logic [15:0] pc;
        logic        last;
    } uop_t;

    uop_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    assign rf_data_1 = rf[rf_rd_addr1];

    lmsm_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dec_valid   (dec_valid),
        .dec_instr   (dec_instr),
        .dec_pc      (dec_pc),
        .dec_ready   (dec_ready),
        .fetch_stall (fetch_stall),
        .rf_rd_addr1 (rf_rd_addr1),
        .rf_data_1   (rf_data_1),
        .rf_rd_addr2 (rf_rd_addr2),
        .ex_ready    (ex_ready),
        .flush       (flush),
        .uop_valid   (uop_valid),
        .uop_load    (uop_load),
        .uop_reg     (uop_reg),
        .uop_addr    (uop_addr),
        .uop_pc      (uop_pc),
        .uop_last    (uop_last)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_uop(input logic load, input logic [2:0] rg, input logic [15:0] addr,
                              input logic [15:0] pc, input logic last);
        uop_t e;
        e.load = load;
        e.rg   = rg;
        e.addr = addr;
        e.pc   = pc;
        e.last = last;
        q.push_back(e);
    endtask

    // Monitor: every presented micro-op must match the queue head; it is consumed only on ex_ready.
    always @(negedge clk) begin
        uop_t e;
        if (rst_n && uop_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_uop: got reg %0d addr %h, expected no micro-op", uop_reg, uop_addr);
            end else begin
                e = q[0];
                if (uop_load !== e.load || uop_reg !== e.rg || uop_addr !== e.addr ||
                    uop_pc !== e.pc || uop_last !== e.last || rf_rd_addr2 !== e.rg) begin
                    errors++;
                    $display("FAIL uop: got load %0b reg %0d addr %h pc %h last %0b rd2 %0d, expected load %0b reg %0d addr %h pc %h last %0b",
                             uop_load, uop_reg, uop_addr, uop_pc, uop_last, rf_rd_addr2,
                             e.load, e.rg, e.addr, e.pc, e.last);
                end
                if (ex_ready) void'(q.pop_front());
            end
        end
    end

    task automatic issue(input logic [15:0] instr, input logic [15:0] pc);
        @(posedge clk);
        #1;
        dec_valid = 1'b1;
        dec_instr = instr;
        dec_pc    = pc;
        @(posedge clk);
        #1;
        dec_valid = 1'b0;
        dec_instr = 16'h0000;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((q.size() != 0 || !dec_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0 || !dec_ready) begin
            errors++;
            $display("FAIL %s_drain: got %0d pending uops dec_ready %0b, expected 0 pending dec_ready 1",
                     name, q.size(), dec_ready);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_uop_valid"},   32'(uop_valid),   32'h0);
        check({tag, "_uop_load"},    32'(uop_load),    32'h0);
        check({tag, "_uop_reg"},     32'(uop_reg),     32'h0);
        check({tag, "_uop_addr"},    32'(uop_addr),    32'h0);
        check({tag, "_uop_pc"},      32'(uop_pc),      32'h0);
        check({tag, "_uop_last"},    32'(uop_last),    32'h0);
        check({tag, "_dec_ready"},   32'(dec_ready),   32'h1);
        check({tag, "_fetch_stall"}, 32'(fetch_stall), 32'h0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_uop_valid"},   32'(uop_valid),   32'h0);
        check({tag, "_dec_ready"},   32'(dec_ready),   32'h1);
        check({tag, "_fetch_stall"}, 32'(fetch_stall), 32'h0);
    endtask

    initial begin
        int stall_cnt;
        for (int i = 0; i < 8; i++) rf[i] = 16'h1000 + 16'(i);
        rf[1] = 16'hFFFE;
        rf[2] = 16'h0040;

        #2;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // LM 0x64A5: Ra = R2 = 0x0040, mask bits 0,2,5,7.
        expect_uop(1'b1, 3'd0, 16'h0040, 16'h0100, 1'b0);
        expect_uop(1'b1, 3'd2, 16'h0041, 16'h0100, 1'b0);
        expect_uop(1'b1, 3'd5, 16'h0042, 16'h0100, 1'b0);
        expect_uop(1'b1, 3'd7, 16'h0043, 16'h0100, 1'b1);
        issue(16'h64A5, 16'h0100);
        stall_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (fetch_stall) stall_cnt++;
            if (i == 0) check("lm_first_cycle_dec_ready", 32'(dec_ready), 32'h0);
            if (i == 4) check("lm_exit_dec_ready", 32'(dec_ready), 32'h1);
        end
        check("lm_stall_cycles", 32'(stall_cnt), 32'd4);
        wait_drain("lm");

        // SM 0x72FF: Ra = R1 = 0xFFFE, all eight registers, address wraps.
        expect_uop(1'b0, 3'd0, 16'hFFFE, 16'h0200, 1'b0);
        expect_uop(1'b0, 3'd1, 16'hFFFF, 16'h0200, 1'b0);
        expect_uop(1'b0, 3'd2, 16'h0000, 16'h0200, 1'b0);
        expect_uop(1'b0, 3'd3, 16'h0001, 16'h0200, 1'b0);
        expect_uop(1'b0, 3'd4, 16'h0002, 16'h0200, 1'b0);
        expect_uop(1'b0, 3'd5, 16'h0003, 16'h0200, 1'b0);
        expect_uop(1'b0, 3'd6, 16'h0004, 16'h0200, 1'b0);
        expect_uop(1'b0, 3'd7, 16'h0005, 16'h0200, 1'b1);
        issue(16'h72FF, 16'h0200);
        wait_drain("sm_wrap");

        // Backpressure: ex_ready low for 3 cycles while the second micro-op is presented.
        expect_uop(1'b1, 3'd0, 16'h0040, 16'h0300, 1'b0);
        expect_uop(1'b1, 3'd2, 16'h0041, 16'h0300, 1'b0);
        expect_uop(1'b1, 3'd5, 16'h0042, 16'h0300, 1'b0);
        expect_uop(1'b1, 3'd7, 16'h0043, 16'h0300, 1'b1);
        issue(16'h64A5, 16'h0300);
        @(posedge clk);
        #1;
        ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(uop_valid), 32'h1);
            check("bp_hold_reg",   32'(uop_reg),   32'd2);
            check("bp_hold_addr",  32'(uop_addr),  32'h0041);
        end
        @(posedge clk);
        #1;
        ex_ready = 1'b1;
        @(negedge clk);
        check("bp_release_reg",  32'(uop_reg),  32'd2);
        check("bp_release_addr", 32'(uop_addr), 32'h0041);
        wait_drain("backpressure");

        // Zero mask is a NOP; other opcodes are ignored.
        @(posedge clk);
        #1;
        dec_valid = 1'b1;
        dec_instr = 16'h6600;
        @(negedge clk);
        check_idle("zero_mask");
        @(posedge clk);
        #1;
        dec_instr = 16'h1234;
        @(negedge clk);
        check_idle("other_op");
        @(posedge clk);
        #1;
        dec_valid = 1'b0;
        dec_instr = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("nop_after");
        end

        // Flush during the third micro-op of an SM run, then a clean LM.
        expect_uop(1'b0, 3'd0, 16'hFFFE, 16'h0500, 1'b0);
        expect_uop(1'b0, 3'd1, 16'hFFFF, 16'h0500, 1'b0);
        expect_uop(1'b0, 3'd2, 16'h0000, 16'h0500, 1'b0);
        issue(16'h72FF, 16'h0500);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check_idle("flush");
        check("flush_queue_empty", 32'(q.size()), 32'd0);
        expect_uop(1'b1, 3'd0, 16'h0040, 16'h0600, 1'b0);
        expect_uop(1'b1, 3'd2, 16'h0041, 16'h0600, 1'b0);
        expect_uop(1'b1, 3'd5, 16'h0042, 16'h0600, 1'b0);
        expect_uop(1'b1, 3'd7, 16'h0043, 16'h0600, 1'b1);
        issue(16'h64A5, 16'h0600);
        wait_drain("post_flush");

        // Asynchronous reset between edges during an LM run.
        expect_uop(1'b1, 3'd0, 16'h0040, 16'h0700, 1'b0);
        expect_uop(1'b1, 3'd2, 16'h0041, 16'h0700, 1'b0);
        expect_uop(1'b1, 3'd5, 16'h0042, 16'h0700, 1'b0);
        expect_uop(1'b1, 3'd7, 16'h0043, 16'h0700, 1'b1);
        issue(16'h64A5, 16'h0700);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("after_reset");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
